sync_bank: RTL and testbench

SYNC_BANK -- requirements
Module: sync_bank

---
 rtl/sync_bank.sv | 83 ++++++++
 tb/tb_sync_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sync_bank.sv
// Multi-channel level synchronizer with per-channel edge pulses.
// Optional per-channel glitch filter compiled in with SYNC_BANK_FILTER_EN.

module sync_bank_lane #(
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              raw;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], din};
  end

  assign raw = chain[STAGES-1];

`ifdef SYNC_BANK_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] cnt;

  // A changed level must persist FILTER_LEN edges before it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (raw == dout) begin
      cnt  <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      dout <= raw;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign dout = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= dout;
  end

  assign rise = dout & ~prev;
  assign fall = ~dout & prev;
endmodule

module sync_bank #(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_any
);
  sync_bank_lane #(
    .STAGES    (STAGES),
    .FILTER_LEN(FILTER_LEN)
  ) u_lane [WIDTH-1:0] (
    .clk (clk),
    .rst (rst),
    .din (async_in),
    .dout(sync_out),
    .rise(rise_pulse),
    .fall(fall_pulse)
  );

  assign change_any = |(rise_pulse | fall_pulse);
endmodule

// File: tb/tb_sync_bank.sv
// Bench for sync_bank: directed scenarios plus random levels against a history-based model.
module tb_sync_bank;
  localparam int FL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] async_in = '0;
  logic [3:0] a_sync, a_rise, a_fall;
  logic       a_chg;
  logic [0:0] b_sync, b_rise, b_fall;
  logic       b_chg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_bank dut_a (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(a_sync),
    .rise_pulse(a_rise), .fall_pulse(a_fall), .change_any(a_chg)
  );

  sync_bank #(.WIDTH(1), .STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .async_in(async_in[0:0]), .sync_out(b_sync),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .change_any(b_chg)
  );

  // Model: input sampled at the j-th edge after reset shows up as raw after
  // STAGES edges; the filter accepts raw after FL consecutive differing edges.
  logic [3:0] hist [0:1023];
  int         k = 0;
  logic [3:0] out_a = '0, prev_a = '0;
  logic       out_b = 1'b0, prev_b = 1'b0;
  int         run_a [4];
  int         run_b = 0;

  function automatic logic [3:0] raw_a();
    return (k >= 2) ? hist[k-2] : 4'b0;
  endfunction

  function automatic logic raw_b();
    logic [3:0] h;
    h = (k >= 3) ? hist[k-3] : 4'b0;
    return h[0];
  endfunction

  task automatic model_edge(input logic [3:0] a, input logic r);
    logic [3:0] ra_old;
    logic       rb_old;
    ra_old = raw_a();
    rb_old = raw_b();
    prev_a = out_a;
    prev_b = out_b;
    if (r) begin
      k = 0; out_a = '0; out_b = 1'b0; prev_a = '0; prev_b = 1'b0;
      for (int i = 0; i < 4; i++) run_a[i] = 0;
      run_b = 0;
    end else begin
      if (k < 1024) hist[k] = a;
      k++;
`ifdef SYNC_BANK_FILTER_EN
      for (int i = 0; i < 4; i++) begin
        if (ra_old[i] == out_a[i]) run_a[i] = 0;
        else begin
          run_a[i]++;
          if (run_a[i] == FL) begin out_a[i] = ra_old[i]; run_a[i] = 0; end
        end
      end
      if (rb_old == out_b) run_b = 0;
      else begin
        run_b++;
        if (run_b == FL) begin out_b = rb_old; run_b = 0; end
      end
`else
      out_a = raw_a();
      out_b = raw_b();
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] er, ef;
    er = out_a & ~prev_a;
    ef = ~out_a & prev_a;
    chk("a_sync", a_sync, out_a);
    chk("a_rise", a_rise, er);
    chk("a_fall", a_fall, ef);
    chk("a_chg", {3'b0, a_chg}, {3'b0, |(er | ef)});
    chk("b_sync", {3'b0, b_sync}, {3'b0, out_b});
    chk("b_rise", {3'b0, b_rise}, {3'b0, out_b & ~prev_b});
    chk("b_fall", {3'b0, b_fall}, {3'b0, ~out_b & prev_b});
    chk("b_chg", {3'b0, b_chg}, {3'b0, out_b ^ prev_b});
  endtask

  task automatic step(input logic [3:0] a, input logic r);
    async_in = a;
    rst      = r;
    @(posedge clk);
    model_edge(a, r);
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) run_a[i] = 0;

    // reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("rst_sync", a_sync, 4'b0000);
    chk("rst_chg", {3'b0, a_chg}, 4'b0000);

    // single-bit rise on channel 0 (and STAGES=3 instance)
    step(4'b0001, 1'b0);
    chk("lat_e1", a_sync, 4'b0000);
    step(4'b0001, 1'b0);
`ifndef SYNC_BANK_FILTER_EN
    chk("lat_e2_sync", a_sync, 4'b0001);
    chk("lat_e2_rise", a_rise, 4'b0001);
    chk("lat_e2_chg", {3'b0, a_chg}, 4'b0001);
    chk("s3_e2_sync", {3'b0, b_sync}, 4'b0000);
`endif
    step(4'b0001, 1'b0);
    chk("rise_once", a_rise, 4'b0000);
`ifndef SYNC_BANK_FILTER_EN
    chk("s3_e3_sync", {3'b0, b_sync}, 4'b0001);
    chk("s3_e3_rise", {3'b0, b_rise}, 4'b0001);
`endif
    repeat (6) step(4'b0001, 1'b0);

    // simultaneous rise and fall on different channels
    step(4'b0000, 1'b1);
    repeat (7) step(4'b1010, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
`ifndef SYNC_BANK_FILTER_EN
    chk("swap_rise", a_rise, 4'b0101);
    chk("swap_fall", a_fall, 4'b1010);
`endif
    repeat (6) step(4'b0101, 1'b0);

    // short glitch on bit 1, then held high
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    repeat (6) step(4'b0000, 1'b0);
`ifdef SYNC_BANK_FILTER_EN
    chk("glitch_sup", a_sync, 4'b0000);
`endif
    repeat (4) step(4'b0010, 1'b0);
`ifdef SYNC_BANK_FILTER_EN
    chk("filt_e4", a_sync, 4'b0000);
`endif
    step(4'b0010, 1'b0);
`ifdef SYNC_BANK_FILTER_EN
    chk("filt_e5_sync", a_sync, 4'b0010);
    chk("filt_e5_rise", a_rise, 4'b0010);
`endif
    repeat (3) step(4'b0010, 1'b0);

    // reset mid-count, input held through release
    step(4'b0000, 1'b1);
    repeat (4) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    chk("midrst_sync", a_sync, 4'b0000);
    chk("midrst_rise", a_rise, 4'b0000);
    repeat (4) step(4'b0001, 1'b0);
`ifdef SYNC_BANK_FILTER_EN
    chk("rerise_e4", a_sync, 4'b0000);
`endif
    step(4'b0001, 1'b0);
    chk("rerise_e5", a_sync, 4'b0001);
    repeat (3) step(4'b0001, 1'b0);

    // random levels with slow-changing and glitchy patterns, occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [3:0] v;
      v = (n % 50 < 25) ? 4'($urandom) : ((($urandom_range(0, 3)) == 0) ? 4'($urandom) : async_in);
      step(v, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
